alien_hit_detector: RTL and testbench

Upstream producer of the `alien_hit` pulse consumed by `score_display`. It owns the alive/dead bitmap of the alien formation. Once per frame it scans the formation cell by cell against the player bullet's bounding box. On the first overlap it kills that alien, emits a one-cycle `alien_hit` plus a `bullet_clear` to the bullet controller, and updates the remaining-alien count.

---
 rtl/invaders_pkg.sv | 30 +++
 rtl/box_overlap.sv | 31 +++
 rtl/alien_hit_detector.sv | 146 ++++++++++++++
 tb/tb_alien_hit_detector.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/invaders_pkg.sv
// Shared constants and types for the invaders formation logic.
//   Formation geometry (rows, columns, sprite sizes, pitches), bullet size,
//   coordinate/index widths and the hit-detector scan state encoding.
package invaders_pkg;

   localparam int unsigned ROWS       = 5;
   localparam int unsigned COLS       = 8;
   localparam int unsigned ALIEN_W    = 16;
   localparam int unsigned ALIEN_H    = 16;
   localparam int unsigned PITCH_X    = 24;
   localparam int unsigned PITCH_Y    = 20;
   localparam int unsigned BULLET_W   = 2;
   localparam int unsigned BULLET_H   = 8;

   localparam int unsigned NUM_ALIENS = ROWS * COLS;

   localparam int unsigned COORD_W    = 10;           // screen coordinate width
   localparam int unsigned SUM_W      = COORD_W + 1;  // cell origins / box sums
   localparam int unsigned ROW_W      = 3;
   localparam int unsigned COL_W      = 3;
   localparam int unsigned IDX_W      = 6;
   localparam int unsigned CNT_W      = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_HIT
   } scan_state_t;

endpackage

// File: rtl/box_overlap.sv
// Strict axis-aligned overlap test between two boxes.
//   a_x/a_y/a_w/a_h : box A top-left and size
//   b_x/b_y/b_w/b_h : box B top-left and size
//   overlap         : 1 when the boxes share at least one pixel
// Sums are widened by one bit so they never wrap.
module box_overlap #(
   parameter int unsigned W = 11
) (
   input  logic [W-1:0] a_x,
   input  logic [W-1:0] a_y,
   input  logic [W-1:0] a_w,
   input  logic [W-1:0] a_h,
   input  logic [W-1:0] b_x,
   input  logic [W-1:0] b_y,
   input  logic [W-1:0] b_w,
   input  logic [W-1:0] b_h,
   output logic         overlap
);

   logic [W:0] a_x_end, a_y_end, b_x_end, b_y_end;

   always_comb begin
      a_x_end = {1'b0, a_x} + {1'b0, a_w};
      a_y_end = {1'b0, a_y} + {1'b0, a_h};
      b_x_end = {1'b0, b_x} + {1'b0, b_w};
      b_y_end = {1'b0, b_y} + {1'b0, b_h};
      overlap = ({1'b0, a_x} < b_x_end) && (a_x_end > {1'b0, b_x}) &&
                ({1'b0, a_y} < b_y_end) && (a_y_end > {1'b0, b_y});
   end

endmodule

// File: rtl/alien_hit_detector.sv
// Alien formation hit detector.
//   Owns the alive bitmap of the formation. On each frame_tick with a bullet
//   in flight it scans cells one per cycle (row-major) against the bullet
//   box; the first live overlapping cell is killed and alien_hit/bullet_clear
//   pulse for one cycle.
// Ports:
//   clk_100MHz, reset        : clock, synchronous active-high reset
//   frame_tick               : starts a scan (ignored while busy)
//   bullet_active/x/y        : player bullet state
//   grid_x/grid_y            : formation origin (cell r0c0 top-left)
//   wave_reload              : revive all aliens, abort any scan
//   alien_hit, bullet_clear  : one-cycle kill pulses
//   hit_row, hit_col         : location of last kill
//   alive_mask               : bit r*COLS+c set when alive
//   aliens_remaining         : alive count; all_cleared when zero
//   busy                     : scan in progress
module alien_hit_detector
   import invaders_pkg::*;
(
   input  logic                    clk_100MHz,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    bullet_active,
   input  logic [COORD_W-1:0]      bullet_x,
   input  logic [COORD_W-1:0]      bullet_y,
   input  logic [COORD_W-1:0]      grid_x,
   input  logic [COORD_W-1:0]      grid_y,
   input  logic                    wave_reload,
   output logic                    alien_hit,
   output logic                    bullet_clear,
   output logic [ROW_W-1:0]        hit_row,
   output logic [COL_W-1:0]        hit_col,
   output logic [NUM_ALIENS-1:0]   alive_mask,
   output logic [CNT_W-1:0]        aliens_remaining,
   output logic                    all_cleared,
   output logic                    busy
);

   scan_state_t state, state_next;

   logic [COORD_W-1:0] bx_q, by_q, gx_q;
   logic [SUM_W-1:0]   cell_x, cell_y;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   col_q;
   logic [IDX_W-1:0]   idx_q;
   logic               scan_start;
   logic               cell_overlap;
   logic               cell_hit;
   logic               last_cell;

   assign all_cleared = (aliens_remaining == '0);

   box_overlap #(.W(SUM_W)) u_overlap (
      .a_x     ({1'b0, bx_q}),
      .a_y     ({1'b0, by_q}),
      .a_w     (SUM_W'(BULLET_W)),
      .a_h     (SUM_W'(BULLET_H)),
      .b_x     (cell_x),
      .b_y     (cell_y),
      .b_w     (SUM_W'(ALIEN_W)),
      .b_h     (SUM_W'(ALIEN_H)),
      .overlap (cell_overlap)
   );

   always_comb begin
      scan_start = (state == ST_IDLE) && frame_tick && bullet_active && !all_cleared;
      cell_hit   = (state == ST_SCAN) && cell_overlap && alive_mask[idx_q];
      last_cell  = (idx_q == IDX_W'(NUM_ALIENS - 1));
   end

   // State register; wave_reload aborts any scan without a pulse.
   always_ff @(posedge clk_100MHz) begin
      if (reset)            state <= ST_IDLE;
      else if (wave_reload) state <= ST_IDLE;
      else                  state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (scan_start) state_next = ST_SCAN;
         ST_SCAN: begin
            if (cell_hit)       state_next = ST_HIT;
            else if (last_cell) state_next = ST_IDLE;
         end
         ST_HIT:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      alien_hit    = (state == ST_HIT);
      bullet_clear = (state == ST_HIT);
      busy         = (state != ST_IDLE);
   end

   // Datapath: snapshots, running cell-origin accumulators and the bitmap.
   // The column accumulator rewinds to the snapshotted grid x at each row end.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         alive_mask       <= '1;
         aliens_remaining <= CNT_W'(NUM_ALIENS);
         hit_row          <= '0;
         hit_col          <= '0;
         bx_q             <= '0;
         by_q             <= '0;
         gx_q             <= '0;
         cell_x           <= '0;
         cell_y           <= '0;
         row_q            <= '0;
         col_q            <= '0;
         idx_q            <= '0;
      end else if (wave_reload) begin
         alive_mask       <= '1;
         aliens_remaining <= CNT_W'(NUM_ALIENS);
      end else if (scan_start) begin
         bx_q   <= bullet_x;
         by_q   <= bullet_y;
         gx_q   <= grid_x;
         cell_x <= {1'b0, grid_x};
         cell_y <= {1'b0, grid_y};
         row_q  <= '0;
         col_q  <= '0;
         idx_q  <= '0;
      end else if (state == ST_SCAN) begin
         if (cell_hit) begin
            alive_mask[idx_q] <= 1'b0;
            aliens_remaining  <= aliens_remaining - 1'b1;
            hit_row           <= row_q;
            hit_col           <= col_q;
         end else begin
            idx_q <= idx_q + 1'b1;
            if (col_q == COL_W'(COLS - 1)) begin
               col_q  <= '0;
               cell_x <= {1'b0, gx_q};
               row_q  <= row_q + 1'b1;
               cell_y <= cell_y + SUM_W'(PITCH_Y);
            end else begin
               col_q  <= col_q + 1'b1;
               cell_x <= cell_x + SUM_W'(PITCH_X);
            end
         end
      end
   end

endmodule

// File: tb/tb_alien_hit_detector.sv
module tb_alien_hit_detector;

   logic        clk;
   logic        reset;
   logic        frame_tick;
   logic        bullet_active;
   logic [9:0]  bullet_x, bullet_y, grid_x, grid_y;
   logic        wave_reload;
   logic        alien_hit, bullet_clear;
   logic [2:0]  hit_row, hit_col;
   logic [39:0] alive_mask;
   logic [5:0]  aliens_remaining;
   logic        all_cleared, busy;

   alien_hit_detector dut (
      .clk_100MHz       (clk),
      .reset            (reset),
      .frame_tick       (frame_tick),
      .bullet_active    (bullet_active),
      .bullet_x         (bullet_x),
      .bullet_y         (bullet_y),
      .grid_x           (grid_x),
      .grid_y           (grid_y),
      .wave_reload      (wave_reload),
      .alien_hit        (alien_hit),
      .bullet_clear     (bullet_clear),
      .hit_row          (hit_row),
      .hit_col          (hit_col),
      .alive_mask       (alive_mask),
      .aliens_remaining (aliens_remaining),
      .all_cleared      (all_cleared),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int row;
      int col;
      int rem;
   } exp_t;

   exp_t sb_q[$];
   int   checks    = 0;
   int   failures  = 0;
   int   pulse_cnt = 0;

   localparam logic [39:0] ALL_ONES = {40{1'b1}};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Monitor: every kill pulse is matched against the scoreboard.
   always @(negedge clk) begin
      if (!reset && (alien_hit || bullet_clear)) begin
         exp_t e;
         pulse_cnt++;
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse actual=1 required=0 cyc=%0d", cyc);
         end else begin
            e = sb_q.pop_front();
            check("pulse_cycle", 64'(cyc), 64'(e.cyc));
            check("pulse_pair", {62'd0, alien_hit, bullet_clear}, 64'd3);
            check("hit_row", 64'(hit_row), 64'(e.row));
            check("hit_col", 64'(hit_col), 64'(e.col));
            check("remaining_at_hit", 64'(aliens_remaining), 64'(e.rem));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input int bx, input int by, output int t);
      bullet_x   = 10'(bx);
      bullet_y   = 10'(by);
      frame_tick = 1'b1;
      t = cyc;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic expect_hit(input int t, input int k, input int row, input int col, input int rem);
      exp_t e;
      e.cyc = t + 2 + k;
      e.row = row;
      e.col = col;
      e.rem = rem;
      sb_q.push_back(e);
   endtask

   task automatic wait_idle(input string name, input int end_cyc);
      int n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      if (busy) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=busy required=idle", name);
      end else begin
         check(name, 64'(cyc), 64'(end_cyc));
      end
   endtask

   task automatic reload();
      wave_reload = 1'b1;
      step();
      wave_reload = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      reset         = 1'b1;
      frame_tick    = 1'b0;
      bullet_active = 1'b1;
      bullet_x      = '0;
      bullet_y      = '0;
      grid_x        = 10'd100;
      grid_y        = 10'd50;
      wave_reload   = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();

      // Reset state
      check("rst_mask", 64'(alive_mask), 64'(ALL_ONES));
      check("rst_remaining", 64'(aliens_remaining), 64'd40);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hit", 64'(alien_hit), 64'd0);
      check("rst_rowcol", {58'd0, hit_row, hit_col}, 64'd0);
      check("rst_all_cleared", 64'(all_cleared), 64'd0);

      // Hit r0c0
      start_frame(105, 55, t);
      expect_hit(t, 0, 0, 0, 39);
      wait_idle("idle_r0c0", t + 3);
      check("mask_bit0", 64'(alive_mask[0]), 64'd0);
      check("remaining_39", 64'(aliens_remaining), 64'd39);

      // Same bullet: r0c0 dead, full miss scan
      start_frame(105, 55, t);
      wait_idle("miss_dead_cell", t + 41);

      // Hit r0c1
      start_frame(130, 55, t);
      expect_hit(t, 1, 0, 1, 38);
      wait_idle("idle_r0c1", t + 4);

      reload();
      check("reload_mask", 64'(alive_mask), 64'(ALL_ONES));
      check("reload_remaining", 64'(aliens_remaining), 64'd40);

      // Right-edge boundary and gap: no hit
      start_frame(116, 55, t);
      wait_idle("miss_edge", t + 41);
      start_frame(118, 55, t);
      wait_idle("miss_gap", t + 41);
      // Last overlapping column pair
      start_frame(114, 55, t);
      expect_hit(t, 0, 0, 0, 39);
      wait_idle("idle_edge_hit", t + 3);

      // Straddle rows 0 and 1: lower index wins, single kill
      reload();
      start_frame(105, 64, t);
      expect_hit(t, 0, 0, 0, 39);
      wait_idle("idle_straddle", t + 3);
      check("straddle_mask", 64'(alive_mask), 64'(ALL_ONES & ~40'd1));

      // wave_reload mid-scan of a bullet that would hit r4c7
      start_frame(270, 135, t);
      repeat (10) step();
      reload();
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_mask", 64'(alive_mask), 64'(ALL_ONES));
      check("abort_remaining", 64'(aliens_remaining), 64'd40);
      repeat (45) step();

      // frame_tick during scan is ignored
      start_frame(118, 55, t);
      repeat (5) step();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      wait_idle("mid_scan_tick", t + 41);
      step();
      step();
      check("no_second_scan", 64'(busy), 64'd0);

      // Kill the whole formation one cell at a time
      pulse_cnt = 0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 8; c++) begin
            int k;
            k = r * 8 + c;
            start_frame(100 + c * 24 + 5, 50 + r * 20 + 5, t);
            expect_hit(t, k, r, c, 39 - k);
            wait_idle("kill_all_idle", t + 3 + k);
         end
      end
      check("kill_all_pulses", 64'(pulse_cnt), 64'd40);
      check("all_cleared", 64'(all_cleared), 64'd1);
      check("cleared_mask", 64'(alive_mask), 64'd0);
      start_frame(105, 55, t);
      check("cleared_tick_ignored", 64'(busy), 64'd0);

      // Reload keeps last kill location
      reload();
      check("reload_keeps_rowcol", {58'd0, hit_row, hit_col}, {58'd0, 3'd4, 3'd7});
      check("reload_all_cleared", 64'(all_cleared), 64'd0);

      // Reset mid-scan of a hitting bullet
      start_frame(270, 135, t);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_rowcol", {58'd0, hit_row, hit_col}, 64'd0);
      check("midrst_mask", 64'(alive_mask), 64'(ALL_ONES));
      check("midrst_remaining", 64'(aliens_remaining), 64'd40);
      repeat (45) step();

      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
